coreport2: RTL and testbench
============================

# coreport2

Second-generation Wishbone GPIO port: WIDTH pins with per-bit direction, output inversion, and atomic set/clear/toggle of the output register. Adds a configurable input synchroniser and per-bit interrupt detection (rising, falling, high or low level) with write-1-to-clear flags. Sits on the peripheral Wishbone bus as a classic-cycle slave. Tristate buffers live outside the block, so it is technology-neutral.

## Interface
- WIDTH, 8: number of GPIO bits, 1..32.
- INITIAL_DATAR, 0: reset value of the output data register.
- INITIAL_DDR, 0: reset value of the direction register; 1 = output.
- SYNC_STAGES, 2: input synchroniser depth, minimum 2.
- wb_clk  in  1  single clock for all logic.
- wb_rst  in  1  synchronous active-high reset.
- wb_adr_i  in  32  byte address; only [7:2] decoded.
- wb_dat_i  in  32  write data; bits above WIDTH ignored.
- wb_we_i, wb_cyc_i, wb_stb_i  in  1  classic Wishbone controls.
- wb_cti_i  in  3, wb_bte_i  in  2  accepted and ignored.
- wb_dat_o  out  32  read data; bits above WIDTH are 0.
- wb_ack_o  out  1  registered acknowledge.
- wb_err_o, wb_rty_o  out  1  tied 0.
- gpio_i  in  WIDTH  pad inputs, asynchronous.
- gpio_o  out  WIDTH  pad output values, equal to datar.
- gpio_oe  out  WIDTH  pad output enables, equal to ddr.
- irq  out  1  registered interrupt, level high.

## Operation
- Register map (byte offsets):
  - 0x00 DATAR: write stores dat^DIR; read returns ((ddr ? datar : s) ^ DIR).
  - 0x04 DDR.
  - 0x08 IMR: interrupt mask.
  - 0x0C IFR: flags. Reads return the flags. Writing 1 clears that bit; writing 0 has no effect.
  - 0x10 IER: 1 = edge, 0 = level.
  - 0x14 DIR: inversion register.
  - 0x18 IPR: 1 = rising or high, 0 = falling or low.
  - 0x1C SET: datar |= dat.
  - 0x20 CLR: datar &= ~dat.
  - 0x24 TGL: datar ^= dat.
  - 0x28 OUT: read-only raw datar.
- SET, CLR and TGL act on the physical level, with no inversion. They read as 0.
- Unmapped offsets read 0, ignore writes, and are still acked.
- Synchroniser: SYNC_STAGES flops per bit. The final stage is s. Register p holds the previous value of s and updates every cycle.
- Detection uses v = s ^ DIR and pv = p ^ DIR:
  - edge, IPR=1: v & ~pv.
  - edge, IPR=0: ~v & pv.
  - level, IPR=1: v.
  - level, IPR=0: ~v.
- IFR[i] sets when the event fires and IMR[i]=1 and DDR[i]=0. The flag stays set until cleared by a W1C write.
- Level flags re-set on the next cycle after a clear while the level persists.
- A set and a W1C clear of the same bit in the same cycle: set wins.
- irq is registered from |IFR.
- Reset:
  - datar=INITIAL_DATAR, ddr=INITIAL_DDR.
  - IMR, IFR, IER, DIR, IPR = 0.
  - Synchroniser flops and p = 0.
  - wb_ack_o=0, wb_dat_o=0, irq=0.
  - Because IMR=0 at reset, pins high at reset produce no flag.

## Timing
- Ack: wb_ack_o <= cyc & stb & ~wb_ack_o.
  - Exactly one ack-high cycle per access; one wait state.
  - A held strobe yields an ack on every other cycle.
- Writes take effect on the edge that raises ack. gpio_o and gpio_oe change on that same edge.
- wb_dat_o is registered on the same edge and valid while ack is high.
- Input latency, counting edge 1 as the first edge that samples a pad change:
  - s changes at edge SYNC_STAGES.
  - IFR sets at edge SYNC_STAGES+1.
  - irq rises at edge SYNC_STAGES+2.
  - DATAR read reflects the change once s has changed.
- W1C of the last set flag drops irq one edge after the ack edge.
- wb_rst asserted mid-transfer: ack drops on the next edge, the write is not performed, and the master must restart.
- Changing IER or IPR does not create events by itself. Only v and pv transitions or level conditions do.

## Test plan
- Reset with INITIAL_DATAR=0xA5, INITIAL_DDR=0x0F -> gpio_o=0xA5, gpio_oe=0x0F, irq=0, OUT reads 0xA5, IFR reads 0.
- DDR=0xFF; SET 0x03, CLR 0x01, TGL 0x80 -> OUT reads 0x82, gpio_o=0x82; each access acked once, one wait state.
- DIR=0xFF, write DATAR 0x0F -> gpio_o=0xF0, DATAR reads 0x0F.
- DDR=0, IMR=0x01, IER=0x01, IPR=1; gpio_i[0] 0->1 -> IFR=0x01 at edge SYNC_STAGES+1, irq at edge +2. A 1->0 change sets no flag. W1C 0x01 -> irq=0.
- Level-low on bit 3 (IER=0, IPR=0, IMR=0x08), pin held low; W1C 0x08 -> IFR re-sets next cycle. Rising edge on bit 3 coincident with W1C -> flag remains 1.
- Bit 2 configured as output with IMR=0x04, pad toggled -> no flag. Reset asserted during a write strobe -> register unchanged, ack low.

Source files
------------

// File: rtl/coreport2.sv
// Wishbone GPIO port: per-bit direction, inversion, atomic set/clear/toggle,
// input synchroniser and per-bit edge/level interrupt flags with W1C clear.
module coreport2 #(
  parameter int unsigned WIDTH         = 8,
  parameter logic [31:0] INITIAL_DATAR = 32'h0,
  parameter logic [31:0] INITIAL_DDR   = 32'h0,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [5:0] A_DATAR = 6'd0;
  localparam logic [5:0] A_DDR   = 6'd1;
  localparam logic [5:0] A_IMR   = 6'd2;
  localparam logic [5:0] A_IFR   = 6'd3;
  localparam logic [5:0] A_IER   = 6'd4;
  localparam logic [5:0] A_DIR   = 6'd5;
  localparam logic [5:0] A_IPR   = 6'd6;
  localparam logic [5:0] A_SET   = 6'd7;
  localparam logic [5:0] A_CLR   = 6'd8;
  localparam logic [5:0] A_TGL   = 6'd9;
  localparam logic [5:0] A_OUT   = 6'd10;

  logic             ack_r, irq_r;
  logic [31:0]      dat_r;
  logic [WIDTH-1:0] datar_r, ddr_r, imr_r, ifr_r, ier_r, dir_r, ipr_r, p_r;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];

  logic             access_s, wr_s, unused_s;
  logic [5:0]       adr_s;
  logic [WIDTH-1:0] wdat_s, s_s, v_s, pv_s, event_s, set_s, clr_s;
  logic [31:0]      rd_s;

  assign access_s = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_s     = access_s & wb_we_i;
  assign adr_s    = wb_adr_i[7:2];
  assign wdat_s   = wb_dat_i[WIDTH-1:0];
  assign s_s      = sync_r[SYNC_STAGES-1];
  assign v_s      = s_s ^ dir_r;
  assign pv_s     = p_r ^ dir_r;
  assign unused_s = ^{wb_adr_i[31:8], wb_adr_i[1:0], wb_cti_i, wb_bte_i, wb_dat_i};

  // Event detection: edge or level, polarity selected per bit, inputs only.
  always_comb begin
    event_s = (ier_r & ((ipr_r & v_s & ~pv_s) | (~ipr_r & ~v_s & pv_s)))
            | (~ier_r & ((ipr_r & v_s) | (~ipr_r & ~v_s)));
    set_s   = event_s & imr_r & ~ddr_r;
    if (wr_s && (adr_s == A_IFR)) begin
      clr_s = wdat_s;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Read data mux; unmapped and write-only offsets read as zero.
  always_comb begin
    rd_s = 32'h0;
    case (adr_s)
      A_DATAR: rd_s[WIDTH-1:0] = ((ddr_r & datar_r) | (~ddr_r & s_s)) ^ dir_r;
      A_DDR:   rd_s[WIDTH-1:0] = ddr_r;
      A_IMR:   rd_s[WIDTH-1:0] = imr_r;
      A_IFR:   rd_s[WIDTH-1:0] = ifr_r;
      A_IER:   rd_s[WIDTH-1:0] = ier_r;
      A_DIR:   rd_s[WIDTH-1:0] = dir_r;
      A_IPR:   rd_s[WIDTH-1:0] = ipr_r;
      A_OUT:   rd_s[WIDTH-1:0] = datar_r;
      default: rd_s = 32'h0;
    endcase
  end

  // Bus handshake, registered read data and interrupt output.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0;
      irq_r <= 1'b0;
    end else begin
      ack_r <= access_s;
      dat_r <= access_s ? rd_s : 32'h0;
      irq_r <= |ifr_r;
    end
  end

  // Configuration and output data registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      datar_r <= INITIAL_DATAR[WIDTH-1:0];
      ddr_r   <= INITIAL_DDR[WIDTH-1:0];
      imr_r   <= {WIDTH{1'b0}};
      ier_r   <= {WIDTH{1'b0}};
      dir_r   <= {WIDTH{1'b0}};
      ipr_r   <= {WIDTH{1'b0}};
    end else if (wr_s) begin
      case (adr_s)
        A_DATAR: datar_r <= wdat_s ^ dir_r;
        A_DDR:   ddr_r   <= wdat_s;
        A_IMR:   imr_r   <= wdat_s;
        A_IER:   ier_r   <= wdat_s;
        A_DIR:   dir_r   <= wdat_s;
        A_IPR:   ipr_r   <= wdat_s;
        A_SET:   datar_r <= datar_r | wdat_s;
        A_CLR:   datar_r <= datar_r & ~wdat_s;
        A_TGL:   datar_r <= datar_r ^ wdat_s;
        default: datar_r <= datar_r;
      endcase
    end else begin
      datar_r <= datar_r;
    end
  end

  // Synchroniser, previous-sample register and sticky flags (set beats clear).
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {WIDTH{1'b0}};
      p_r   <= {WIDTH{1'b0}};
      ifr_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      p_r   <= s_s;
      ifr_r <= (ifr_r & ~clr_s) | set_s;
    end
  end

  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign gpio_o   = datar_r;
  assign gpio_oe  = ddr_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_coreport2.sv
// Directed self-checking bench for coreport2 (WIDTH=8, DATAR=0xA5, DDR=0x0F).
module tb_coreport2;

  logic        wb_clk, wb_rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o, wb_rty_o, irq;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;
  logic [31:0] rdata;
  int          n_pass, n_total;

  coreport2 #(.WIDTH(8), .INITIAL_DATAR(32'hA5), .INITIAL_DDR(32'h0F), .SYNC_STAGES(2)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i),
    .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  // One access: ack must appear after exactly one edge and drop after the next.
  task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          output logic [31:0] rd);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick(1);
    chk("ack_high", {31'h0, wb_ack_o}, 32'h1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick(1);
    chk("ack_low", {31'h0, wb_ack_o}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_cycle(adr, 1'b1, dat, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_cycle(adr, 1'b0, 32'h0, d);
    chk(tag, d, exp);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    wb_rst = 1'b1; wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'h0; wb_bte_i = 2'h0; gpio_i = 8'h00;
    tick(3);
    wb_rst = 1'b0;

    // Reset state
    chk("rst_gpio_o", {24'h0, gpio_o}, 32'hA5);
    chk("rst_gpio_oe", {24'h0, gpio_oe}, 32'h0F);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_dat_o", wb_dat_o, 32'h0);
    rd_chk("rst_out", 32'h28, 32'hA5);
    rd_chk("rst_ifr", 32'h0C, 32'h0);
    rd_chk("unmapped", 32'h3C, 32'h0);

    // Held strobe: ack on alternate cycles
    wb_adr_i = 32'h28; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick(1); chk("held_ack1", {31'h0, wb_ack_o}, 32'h1);
    tick(1); chk("held_ack2", {31'h0, wb_ack_o}, 32'h0);
    tick(1); chk("held_ack3", {31'h0, wb_ack_o}, 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick(1);

    // Atomic set/clear/toggle
    wr(32'h04, 32'hFF);
    chk("ddr_oe", {24'h0, gpio_oe}, 32'hFF);
    wr(32'h00, 32'h00);
    wr(32'h1C, 32'h03);
    wr(32'h20, 32'h01);
    wr(32'h24, 32'h80);
    rd_chk("out_sct", 32'h28, 32'h82);
    chk("gpio_o_sct", {24'h0, gpio_o}, 32'h82);
    rd_chk("set_reads0", 32'h1C, 32'h0);

    // Inversion
    wr(32'h14, 32'hFF);
    wr(32'h00, 32'h0F);
    chk("inv_gpio_o", {24'h0, gpio_o}, 32'hF0);
    rd_chk("inv_datar", 32'h00, 32'h0F);
    wr(32'h14, 32'h00);

    // Rising edge on bit 0
    wr(32'h04, 32'h00);
    wr(32'h10, 32'h01);
    wr(32'h18, 32'h01);
    wr(32'h08, 32'h01);
    rd_chk("ifr_idle", 32'h0C, 32'h0);
    gpio_i = 8'h01;
    tick(2); chk("irq_e2", {31'h0, irq}, 32'h0);
    tick(1); chk("irq_e3", {31'h0, irq}, 32'h0);
    tick(1); chk("irq_e4", {31'h0, irq}, 32'h1);
    rd_chk("ifr_rise", 32'h0C, 32'h01);
    rd_chk("datar_in", 32'h00, 32'h01);
    wr(32'h0C, 32'h01);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    gpio_i = 8'h00;
    tick(5);
    chk("irq_fall", {31'h0, irq}, 32'h0);
    rd_chk("ifr_fall", 32'h0C, 32'h0);

    // Level-low on bit 3 re-sets after clear
    wr(32'h08, 32'h08);
    wr(32'h10, 32'h00);
    wr(32'h18, 32'h00);
    tick(2);
    rd_chk("ifr_level", 32'h0C, 32'h08);
    wr(32'h0C, 32'h08);
    rd_chk("ifr_reset", 32'h0C, 32'h08);
    chk("irq_level", {31'h0, irq}, 32'h1);

    // Rising edge on bit 3 coincident with W1C: set wins
    wr(32'h10, 32'h08);
    wr(32'h18, 32'h08);
    wr(32'h0C, 32'h08);
    rd_chk("ifr_edge_clr", 32'h0C, 32'h0);
    gpio_i = 8'h08;
    tick(2);
    wr(32'h0C, 32'h08);
    rd_chk("ifr_set_wins", 32'h0C, 32'h08);

    // Output bit never flags
    wr(32'h04, 32'h04);
    wr(32'h08, 32'h04);
    wr(32'h0C, 32'hFF);
    gpio_i = 8'h0C;
    tick(4);
    gpio_i = 8'h08;
    tick(4);
    rd_chk("ifr_output", 32'h0C, 32'h0);
    chk("irq_output", {31'h0, irq}, 32'h0);

    // Reset during a write strobe
    wb_adr_i = 32'h04; wb_dat_i = 32'hFF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_rst = 1'b1;
    tick(1);
    chk("rst_mid_ack", {31'h0, wb_ack_o}, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_rst = 1'b0;
    tick(1);
    chk("rst_mid_oe", {24'h0, gpio_oe}, 32'h0F);
    chk("rst_mid_o", {24'h0, gpio_o}, 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
